// File: rtl/cache_pkg.sv
// Shared definitions for the 8-way cache tag-lookup stage.
// Optional feature macro: CACHE_PLRU_EN (tree pseudo-LRU replacement instead of round-robin).
package cache_pkg;

    localparam int WAYS   = 8;
    localparam int WAY_W  = 3;
    localparam int PLRU_W = 7;

`ifdef CACHE_PLRU_EN
    localparam int REPL_W = PLRU_W;
`else
    localparam int REPL_W = WAY_W;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/cache_plru8.sv
// Combinational replacement logic for one set: victim select and state update on touch.
// Optional feature macro: CACHE_PLRU_EN selects the 7-bit tree pseudo-LRU; otherwise a
// 3-bit round-robin pointer that only advances on fills.
module cache_plru8
    import cache_pkg::*;
(
    input  logic [REPL_W-1:0] i_state,
    input  logic [WAY_W-1:0]  i_touch_way,
    input  logic              i_is_fill,
    output logic [WAY_W-1:0]  o_victim,
    output logic [REPL_W-1:0] o_next_state
);

`ifdef CACHE_PLRU_EN
    logic w_unused_fill;
    assign w_unused_fill = i_is_fill;

    // Walk the tree from the root; a node bit of 0 sends the victim into the lower half.
    always_comb begin
        o_victim[2] = i_state[0];
        o_victim[1] = i_state[0] ? i_state[2] : i_state[1];
        case ({i_state[0], o_victim[1]})
            2'b00:   o_victim[0] = i_state[3];
            2'b01:   o_victim[0] = i_state[4];
            2'b10:   o_victim[0] = i_state[5];
            default: o_victim[0] = i_state[6];
        endcase
    end

    // Every node on the path to the touched way is flipped to point away from it.
    always_comb begin
        o_next_state    = i_state;
        o_next_state[0] = ~i_touch_way[2];
        if (i_touch_way[2]) begin
            o_next_state[2] = ~i_touch_way[1];
        end else begin
            o_next_state[1] = ~i_touch_way[1];
        end
        case (i_touch_way[2:1])
            2'b00:   o_next_state[3] = ~i_touch_way[0];
            2'b01:   o_next_state[4] = ~i_touch_way[0];
            2'b10:   o_next_state[5] = ~i_touch_way[0];
            default: o_next_state[6] = ~i_touch_way[0];
        endcase
    end
`else
    logic w_unused_touch;
    assign w_unused_touch = ^i_touch_way;

    // The pointer is the victim and advances (mod 8) only when the set is refilled.
    always_comb begin
        o_victim     = i_state;
        o_next_state = i_is_fill ? i_state + 3'd1 : i_state;
    end
`endif

endmodule

// File: rtl/cache_way_lookup.sv
// Tag lookup and replacement stage for an 8-way set-associative cache.
// Returns hit and way select one cycle after a request is accepted, installs fills,
// and runs a one-set-per-cycle invalidate-all flush.
// Optional feature macro: CACHE_PLRU_EN (tree pseudo-LRU replacement).
module cache_way_lookup
    import cache_pkg::*;
#(
    parameter int TAG_W = 20,
    parameter int IDX_W = 4
)(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [IDX_W-1:0] i_req_index,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_resp_valid,
    output logic             o_resp_hit,
    output logic [WAY_W-1:0] o_resp_way_sel,
    input  logic             i_fill_valid,
    input  logic [IDX_W-1:0] i_fill_index,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic [WAY_W-1:0] i_fill_way,
    input  logic             i_flush,
    output logic             o_flush_busy
);

    localparam int NUM_SETS = 1 << IDX_W;

    logic [TAG_W-1:0]  r_tag   [NUM_SETS][WAYS];
    logic [WAYS-1:0]   r_valid [NUM_SETS];
    logic [REPL_W-1:0] r_repl  [NUM_SETS];
    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_flush_cnt;
    logic              r_resp_valid;
    logic              r_resp_hit;
    logic [WAY_W-1:0]  r_resp_way;

    logic              w_accept;
    logic              w_fill_en;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_has_inv;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_victim;
    logic [WAY_W-1:0]  w_sel;
    logic [REPL_W-1:0] w_hit_repl;
    logic [REPL_W-1:0] w_fill_repl;
    logic [WAY_W-1:0]  w_fill_victim_unused;

    assign w_accept  = i_req_valid && o_req_ready;
    assign w_fill_en = i_fill_valid && (r_state == ST_IDLE);
    assign w_sel     = w_hit ? w_hit_way : (w_has_inv ? w_inv_way : w_victim);

    assign o_resp_valid   = r_resp_valid;
    assign o_resp_hit     = r_resp_hit;
    assign o_resp_way_sel = r_resp_way;

    // Compare against all ways; scanning downward lets the lowest matching/invalid way win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[i_req_index][w] && (r_tag[i_req_index][w] == i_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[i_req_index][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    cache_plru8 u_lookup_repl (
        .i_state      (r_repl[i_req_index]),
        .i_touch_way  (w_hit_way),
        .i_is_fill    (1'b0),
        .o_victim     (w_victim),
        .o_next_state (w_hit_repl)
    );

    cache_plru8 u_fill_repl (
        .i_state      (r_repl[i_fill_index]),
        .i_touch_way  (i_fill_way),
        .i_is_fill    (1'b1),
        .o_victim     (w_fill_victim_unused),
        .o_next_state (w_fill_repl)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and status outputs; flush requests during a flush are ignored.
    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_flush_busy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_flush) begin
                    w_next_state = ST_FLUSH;
                end
            end
            default: begin
                o_flush_busy = 1'b1;
                if (r_flush_cnt == IDX_W'(NUM_SETS - 1)) begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    // Flush walks the sets in order and naturally wraps back to zero on the last one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flush_cnt <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end else begin
            r_flush_cnt <= '0;
        end
    end

    // Valid and replacement state; a same-set fill is written last so it overrides the hit touch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_repl[s]  <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            r_valid[r_flush_cnt] <= '0;
            r_repl[r_flush_cnt]  <= '0;
        end else begin
            if (w_accept && w_hit) begin
                r_repl[i_req_index] <= w_hit_repl;
            end
            if (w_fill_en) begin
                r_valid[i_fill_index][i_fill_way] <= 1'b1;
                r_repl[i_fill_index]              <= w_fill_repl;
            end
        end
    end

    // Tag storage is only meaningful behind a valid bit, so it is never reset.
    always_ff @(posedge i_clk) begin
        if (w_fill_en) begin
            r_tag[i_fill_index][i_fill_way] <= i_fill_tag;
        end
    end

    // Response registers: one-cycle strobe carrying the result computed from pre-edge state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept) begin
                r_resp_hit <= w_hit;
                r_resp_way <= w_sel;
            end
        end
    end

endmodule
